ps2_scancode_receiver: RTL and testbench
========================================

PS2_SCANCODE_RECEIVER -- requirements
Module: ps2_scancode_receiver

Interface
REQ-001 Parameter FILTER_DEPTH, default 8: number of consecutive equal samples needed to change the filtered PS/2 clock level.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two: number of decoded key events buffered.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000 (2 ms at 50 MHz): maximum Clock cycles allowed between PS/2 clock falling edges inside one frame.
REQ-004 Clock  input  1  system clock (50 MHz); one clock only.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 iPS2_CLK  input  1  raw PS/2 clock line, asynchronous.
REQ-007 iPS2_DATA  input  1  raw PS/2 data line, asynchronous.
REQ-008 iRead  input  1  pop request; honoured only while oValid=1.
REQ-009 oScanCode  output  8  scan code at FIFO head.
REQ-010 oBreak  output  1  head event was prefixed by 8'hF0 (key release).
REQ-011 oExtended  output  1  head event was prefixed by 8'hE0.
REQ-012 oValid  output  1  FIFO not empty.
REQ-013 oFrameError  output  1  one-cycle pulse on parity, start, stop or timeout error.
REQ-014 oOverflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 iPS2_CLK and iPS2_DATA SHALL each pass through a 2-FF synchronizer.
REQ-016 Filtered clock SHALL go 1 after FILTER_DEPTH consecutive synchronized 1s, go 0 after FILTER_DEPTH consecutive 0s, and hold otherwise.
REQ-017 A bit SHALL be sampled from synchronized data in the cycle the filtered clock transitions 1->0.
REQ-018 Frame FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled 0 (start bit), sampled 1 in IDLE ignored.
REQ-019 DATA SHALL collect 8 bits LSB first, then go to PARITY; PARITY->STOP after one bit; STOP->IDLE after one bit.
REQ-020 Frame valid iff the 8 data bits plus the parity bit have odd weight and the stop bit is 1; otherwise oFrameError pulses and the byte is discarded.
REQ-021 In DATA/PARITY/STOP, TIMEOUT_CYCLES cycles with no sampled edge SHALL return the FSM to IDLE, pulse oFrameError, and discard the partial frame.
REQ-022 Valid byte 8'hE0 sets the extended-pending flag; 8'hF0 sets the break-pending flag; neither is pushed.
REQ-023 Any other valid byte SHALL push {extended-pending, break-pending, byte} into the FIFO in the cycle after the stop-bit sample and clear both pending flags.
REQ-024 A frame error SHALL clear both pending flags.
REQ-025 FIFO SHALL be first-word-fall-through: oScanCode/oBreak/oExtended reflect the head whenever oValid=1, and oValid rises the cycle after the push.
REQ-026 iRead with oValid=1 SHALL pop at the clock edge; iRead with oValid=0 SHALL be ignored.
REQ-027 Push while full without a simultaneous pop SHALL drop the new event and pulse oOverflow; push and pop in the same cycle while full SHALL both succeed.
REQ-028 Push and pop in the same cycle while non-empty SHALL leave the occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-029 Outputs oScanCode/oBreak/oExtended SHALL be 0 while oValid=0.

Reset
REQ-030 Reset SHALL force FSM=IDLE, bit counter and timeout counter=0, pending flags=0, FIFO empty, synchronizers and filter to 1, and filtered clock to 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no oFrameError pulse; all outputs are 0 in the cycle after Reset.

Structure
REQ-032 FSM state encodings and prefix constants 8'hE0 and 8'hF0 SHALL live in the shared definitions include.
REQ-033 The synchronizer plus filter plus falling-edge detector SHALL be one sub-module, ps2_glitch_filter, reused for both lines; the FIFO stays inline.

Verification
REQ-034 Frame 8'h1C, parity 0, stop 1, at a 12.5 kHz PS/2 clock -> oValid rises, head={0,0,8'h1C}; iRead pulse -> oValid=0.
REQ-035 Frames E0, F0, 75 -> exactly one event {1,1,8'h75}; no event for the prefixes.
REQ-036 Frame 8'h1C with parity bit 1 -> one oFrameError pulse, oValid stays 0; a following good 8'h32 is received correctly.
REQ-037 Six good frames (8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36) with no reads -> first four held, two oOverflow pulses; reads return 16,1E,26,25 in order.
REQ-038 Clock stopped after 4 data bits for TIMEOUT_CYCLES+1 cycles -> oFrameError pulse, FSM IDLE; 3-cycle glitches on iPS2_CLK -> no bit sampled.
REQ-039 Reset asserted after the 5th data bit -> no event, no error; the next full frame 8'h1C decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_receiver_pkg.sv
// PS/2 scancode receiver shared definitions.
// Frame FSM states, prefix bytes, key event bundle.
package ps2_scancode_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_ev_t;

  function automatic logic frame_ok(
    input logic [7:0] d,
    input logic       p,
    input logic       s
  );
    return (^{d, p}) & s;
  endfunction

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// PS/2 receiver bus: raw PS/2 lines in,
// FWFT key event queue and status pulses out.
interface ps2_scancode_receiver_if;

  logic       iPS2_CLK;
  logic       iPS2_DATA;
  logic       iRead;
  logic [7:0] oScanCode;
  logic       oBreak;
  logic       oExtended;
  logic       oValid;
  logic       oFrameError;
  logic       oOverflow;

  modport master (
    input  iPS2_CLK,
    input  iPS2_DATA,
    input  iRead,
    output oScanCode,
    output oBreak,
    output oExtended,
    output oValid,
    output oFrameError,
    output oOverflow
  );

  modport slave (
    output iPS2_CLK,
    output iPS2_DATA,
    output iRead,
    input  oScanCode,
    input  oBreak,
    input  oExtended,
    input  oValid,
    input  oFrameError,
    input  oOverflow
  );

endinterface

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchronizer, run-length level filter
// and falling-edge strobe for one PS/2 line.
module ps2_glitch_filter #(
  parameter int DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_sync,
  output logic o_fall
);

  logic             r_meta;
  logic             r_sync;
  logic             r_filt;
  logic [DEPTH-1:0] r_hist;
  logic             w_all1;
  logic             w_all0;

  assign w_all1 = &r_hist;
  assign w_all0 = ~|r_hist;

  // Synchronize, keep a sample history, move level only on a full run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= '1;
      r_filt <= 1'b1;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_hist <= {r_hist[DEPTH-2:0], r_sync};
      if (w_all1)
        r_filt <= 1'b1;
      else if (w_all0)
        r_filt <= 1'b0;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_filt & w_all0;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix
// folding and a first-word-fall-through event queue.
module ps2_scancode_receiver
  import ps2_scancode_receiver_pkg::*;
#(
  parameter int FILTER_DEPTH   = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                    Clock,
  input logic                    Reset,
  ps2_scancode_receiver_if.master ps2
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic w_clk_fall;
  logic w_clk_sync_unused;
  logic w_data_sync;
  logic w_data_fall_unused;

  ps2_glitch_filter #(.DEPTH(FILTER_DEPTH)) u_clk_flt (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_raw  (ps2.iPS2_CLK),
    .o_sync (w_clk_sync_unused),
    .o_fall (w_clk_fall)
  );

  ps2_glitch_filter #(.DEPTH(FILTER_DEPTH)) u_data_flt (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_raw  (ps2.iPS2_DATA),
    .o_sync (w_data_sync),
    .o_fall (w_data_fall_unused)
  );

  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_ext;
  logic          r_brk;
  logic          r_push;
  key_ev_t       r_push_ev;
  logic          r_err;

  logic w_ok;
  logic w_bad;
  logic w_is_ext;
  logic w_is_brk;
  logic w_is_key;

  assign w_ok     = frame_ok(r_shift, r_par, w_data_sync);
  assign w_bad    = ~w_ok;
  assign w_is_ext = w_ok & (r_shift == PFX_EXT);
  assign w_is_brk = w_ok & (r_shift == PFX_BRK);
  assign w_is_key = w_ok & ~w_is_ext & ~w_is_brk;

  // Frame FSM: bit capture, timeout, prefix folding, push strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_tmo     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_push    <= 1'b0;
      r_push_ev <= '0;
      r_err     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != ST_IDLE && !w_clk_fall) begin
        if (r_tmo == TMO_LAST) begin
          r_state  <= ST_IDLE;
          r_tmo    <= '0;
          r_bitcnt <= '0;
          r_err    <= 1'b1;
          r_ext    <= 1'b0;
          r_brk    <= 1'b0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else if (w_clk_fall) begin
        r_tmo <= '0;
        unique case (r_state)
          ST_IDLE: begin
            if (!w_data_sync) begin
              r_state  <= ST_DATA;
              r_bitcnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift  <= {w_data_sync, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7)
              r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= w_data_sync;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            unique case (1'b1)
              w_bad: begin
                r_err <= 1'b1;
                r_ext <= 1'b0;
                r_brk <= 1'b0;
              end
              w_is_ext: r_ext <= 1'b1;
              w_is_brk: r_brk <= 1'b1;
              w_is_key: begin
                r_push    <= 1'b1;
                r_push_ev <= '{ext: r_ext, brk: r_brk, code: r_shift};
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
              end
            endcase
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  key_ev_t       r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic    w_empty;
  logic    w_full;
  logic    w_pop;
  logic    w_wr;
  logic    w_drop;
  key_ev_t w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);
  assign w_pop   = ps2.iRead & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;

  // Event storage; a full-queue write reuses the slot being popped.
  always_ff @(posedge Clock) begin
    if (w_wr)
      r_mem[r_wptr] <= r_push_ev;
  end

  // Queue pointers, occupancy and overflow strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_wr)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rptr];

  assign ps2.oScanCode   = w_head.code;
  assign ps2.oBreak      = w_head.brk;
  assign ps2.oExtended   = w_head.ext;
  assign ps2.oValid      = ~w_empty;
  assign ps2.oFrameError = r_err;
  assign ps2.oOverflow   = r_ovf;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver.
// PS/2 clock runs faster than a real keyboard to keep runs short.
module tb_ps2_scancode_receiver;

  localparam int FD   = 8;
  localparam int QD   = 4;
  localparam int TMO  = 400;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_err   = 0;
  int   n_ovf   = 0;

  always #5 clk = ~clk;

  ps2_scancode_receiver_if u_if ();

  ps2_scancode_receiver #(
    .FILTER_DEPTH   (FD),
    .FIFO_DEPTH     (QD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .ps2   (u_if)
  );

  always @(negedge clk) begin
    if (u_if.oFrameError) n_err++;
    if (u_if.oOverflow)   n_ovf++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    u_if.iPS2_DATA = b;
    cyc(HALF);
    u_if.iPS2_CLK = 1'b0;
    cyc(HALF);
    u_if.iPS2_CLK = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad);
    send_bit(1'b1);
    cyc(HALF);
  endtask

  task automatic pop();
    u_if.iRead = 1'b1;
    cyc(1);
    u_if.iRead = 1'b0;
    cyc(1);
  endtask

  function automatic logic [9:0] head();
    return {u_if.oExtended, u_if.oBreak, u_if.oScanCode};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(1);
    n_tests++;
    if (u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", u_if.oValid);
    end
    n_tests++;
    if (head() !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_head got %h want 000", head());
    end
    n_tests++;
    if (u_if.oFrameError !== 1'b0 || u_if.oOverflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b%b want 00",
               u_if.oFrameError, u_if.oOverflow);
    end
  endtask

  task automatic test_single();
    int e0;
    e0 = n_err;
    send_frame(8'h1C, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b00, 8'h1C}) begin
      n_fail++;
      $display("FAIL single_head got v=%b %h want v=1 01c",
               u_if.oValid, head());
    end
    n_tests++;
    if (n_err != e0) begin
      n_fail++;
      $display("FAIL single_err got %0d want 0", n_err - e0);
    end
    pop();
    n_tests++;
    if (u_if.oValid !== 1'b0 || head() !== 10'h000) begin
      n_fail++;
      $display("FAIL single_pop got v=%b %h want v=0 000",
               u_if.oValid, head());
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL prefix_nopush got v=%b want 0", u_if.oValid);
    end
    send_frame(8'h75, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b11, 8'h75}) begin
      n_fail++;
      $display("FAIL prefix_head got v=%b %h want v=1 375",
               u_if.oValid, head());
    end
    pop();
    n_tests++;
    if (u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL prefix_single got v=%b want 0", u_if.oValid);
    end
  endtask

  task automatic test_parity_error();
    int e0;
    send_frame(8'hF0, 1'b0);
    e0 = n_err;
    send_frame(8'h1C, 1'b1);
    n_tests++;
    if (n_err - e0 != 1 || u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_err got errs=%0d v=%b want errs=1 v=0",
               n_err - e0, u_if.oValid);
    end
    send_frame(8'h32, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b00, 8'h32}) begin
      n_fail++;
      $display("FAIL parity_next got v=%b %h want v=1 032",
               u_if.oValid, head());
    end
    pop();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [6];
    int o0;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
    o0 = n_ovf;
    for (int i = 0; i < 6; i++) send_frame(codes[i], 1'b0);
    n_tests++;
    if (n_ovf - o0 != 2) begin
      n_fail++;
      $display("FAIL ovf_count got %0d want 2", n_ovf - o0);
    end
    for (int i = 0; i < QD; i++) begin
      n_tests++;
      if (u_if.oValid !== 1'b1 || head() !== {2'b00, codes[i]}) begin
        n_fail++;
        $display("FAIL ovf_read%0d got v=%b %h want v=1 0%h",
                 i, u_if.oValid, head(), codes[i]);
      end
      pop();
    end
    n_tests++;
    if (u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain got v=%b want 0", u_if.oValid);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_err;
    send_partial(8'h1C, 4);
    cyc(TMO + 1 + 20);
    n_tests++;
    if (n_err - e0 != 1 || u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err got errs=%0d v=%b want errs=1 v=0",
               n_err - e0, u_if.oValid);
    end
    send_frame(8'h1C, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b00, 8'h1C}) begin
      n_fail++;
      $display("FAIL tmo_idle got v=%b %h want v=1 01c",
               u_if.oValid, head());
    end
    pop();
    e0 = n_err;
    u_if.iPS2_DATA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(10);
      u_if.iPS2_CLK = 1'b0;
      cyc(3);
      u_if.iPS2_CLK = 1'b1;
    end
    u_if.iPS2_DATA = 1'b1;
    cyc(TMO + 40);
    n_tests++;
    if (n_err != e0 || u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_quiet got errs=%0d v=%b want errs=0 v=0",
               n_err - e0, u_if.oValid);
    end
    send_frame(8'h26, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b00, 8'h26}) begin
      n_fail++;
      $display("FAIL glitch_next got v=%b %h want v=1 026",
               u_if.oValid, head());
    end
    pop();
  endtask

  task automatic test_reset_midframe();
    int e0;
    send_frame(8'h45, 1'b0);
    e0 = n_err;
    send_partial(8'h1C, 5);
    rst = 1'b1;
    cyc(1);
    n_tests++;
    if (u_if.oValid !== 1'b0 || head() !== 10'h000 ||
        u_if.oFrameError !== 1'b0 || u_if.oOverflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_out got v=%b %h e=%b o=%b want all 0",
               u_if.oValid, head(), u_if.oFrameError, u_if.oOverflow);
    end
    rst = 1'b0;
    cyc(TMO + 40);
    n_tests++;
    if (n_err != e0 || u_if.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet got errs=%0d v=%b want errs=0 v=0",
               n_err - e0, u_if.oValid);
    end
    send_frame(8'h1C, 1'b0);
    n_tests++;
    if (u_if.oValid !== 1'b1 || head() !== {2'b00, 8'h1C}) begin
      n_fail++;
      $display("FAIL rstmid_next got v=%b %h want v=1 01c",
               u_if.oValid, head());
    end
    pop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.iPS2_CLK  = 1'b1;
    u_if.iPS2_DATA = 1'b1;
    u_if.iRead     = 1'b0;
    test_reset();
    test_single();
    test_prefix();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
